// File: rtl/tube_seq_pkg.sv
// Shared types and constants for the drift-tube event readout sequencer.
// Contents: FSM state enum, trailer/header constants, "no hit" time helper,
// and the readout word width calculation.
package tube_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_CAPTURE = 3'd2,
    S_READOUT = 3'd3,
    S_TRAILER = 3'd4,
    S_DEAD    = 3'd5
  } seq_state_e;

  // Trailer is all ones at whatever the readout word width is; slice the low bits.
  localparam logic [255:0] TRAILER_WORD = '1;

  // Tag placed in the top byte of the optional per-event header word.
  localparam logic [7:0] HEADER_TAG = 8'hA5;

  // All-ones time value of width w (w in 1..31); reserved to mean "no hit".
  function automatic logic [31:0] no_hit(input int w);
    return ~(32'hFFFF_FFFF << w);
  endfunction

  function automatic int data_w(input int time_w, input int ch_id_w);
    return time_w + ch_id_w;
  endfunction

endpackage

// File: rtl/tube_hit_tdc.sv
// Per-channel first-hit TDC: synchronises one async tube input, detects its
// rising edge and latches the shared window counter on the first edge while armed.
// Ports: clk50, rst_n (sync, active low), clr, arm, tcnt, tube (async), hit_time.
module tube_hit_tdc
  import tube_seq_pkg::*;
#(
  parameter int TIME_W = 8
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              arm,
  input  logic [TIME_W-1:0] tcnt,
  input  logic              tube,
  output logic [TIME_W-1:0] hit_time
);

  localparam logic [TIME_W-1:0] NO_HIT = TIME_W'(no_hit(TIME_W));

  logic              sync1_q, sync2_q, prev_q;
  logic [TIME_W-1:0] hit_q, hit_d;
  logic              rise;

  // Edge history runs continuously, so a tube already high when the window
  // opens produces no edge and records nothing.
  assign rise = sync2_q & ~prev_q;

  always_comb begin
    hit_d = hit_q;
    if (clr) begin
      hit_d = NO_HIT;
    end else if (arm && rise && (hit_q == NO_HIT)) begin
      hit_d = tcnt;
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hit_q   <= NO_HIT;
    end else begin
      sync1_q <= tube;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      hit_q   <= hit_d;
    end
  end

  assign hit_time = hit_q;

endmodule

// File: rtl/tube_event_sequencer.sv
// Drift-tube event readout sequencer: a synchronised coincidence edge opens a
// capture window, then one {time, ch_id} word per channel and an all-ones
// trailer are written to the readout FIFO, stalling while fifo_full is high.
// Ports: clk50, rst_n (sync, active low), scin_coin, tube_in[NUM_CH] (async in);
//        fifo_din, fifo_wr_en (registered), busy, missed_trig (sticky), evt_count.
// Optional: define EVT_HEADER_EN to emit an {A5, evt_count[7:0]} header word
// before each event's capture window.
module tube_event_sequencer
  import tube_seq_pkg::*;
#(
  parameter int NUM_CH      = 32,
  parameter int TIME_W      = 8,
  parameter int CH_ID_W     = 8,
  parameter int WINDOW      = 254,
  parameter int DEAD_CYCLES = 11,
  localparam int DATA_W     = data_w(TIME_W, CH_ID_W)
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              scin_coin,
  input  logic [NUM_CH-1:0] tube_in,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              busy,
  output logic              missed_trig,
  output logic [15:0]       evt_count
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [TIME_W-1:0] tcnt_q, tcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wr_q, wr_d;
  logic              missed_q, missed_d;
  logic [15:0]       evt_q, evt_d;

  logic trig_s1_q, trig_s2_q, trig_prev_q;
  logic trig_rise;

  logic [TIME_W-1:0] hit_time [NUM_CH];
  logic              tdc_clr, tdc_arm;

  assign trig_rise = trig_s2_q & ~trig_prev_q;
  assign tdc_clr   = (state_q == S_DEAD);
  assign tdc_arm   = (state_q == S_CAPTURE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tdc
    tube_hit_tdc #(.TIME_W(TIME_W)) u_tdc (
      .clk50    (clk50),
      .rst_n    (rst_n),
      .clr      (tdc_clr),
      .arm      (tdc_arm),
      .tcnt     (tcnt_q),
      .tube     (tube_in[g]),
      .hit_time (hit_time[g])
    );
  end

`ifdef EVT_HEADER_EN
  logic [DATA_W-1:0] hdr_word;
  always_comb begin
    hdr_word                 = '0;
    hdr_word[DATA_W-1 -: 8]  = HEADER_TAG;
    hdr_word[7:0]            = evt_q[7:0];
  end
`endif

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    din_d    = din_q;
    wr_d     = 1'b0;
    evt_d    = evt_q;
    // Any trigger edge outside IDLE is lost; remember that until reset.
    missed_d = missed_q | (trig_rise && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
`ifdef EVT_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_CAPTURE;
          tcnt_d  = '0;
`endif
        end
      end
`ifdef EVT_HEADER_EN
      S_HEADER: begin
        if (!fifo_full) begin
          din_d   = hdr_word;
          wr_d    = 1'b1;
          state_d = S_CAPTURE;
          tcnt_d  = '0;
        end
      end
`endif
      S_CAPTURE: begin
        if (tcnt_q == TIME_W'(WINDOW - 1)) begin
          state_d = S_READOUT;
          idx_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_READOUT: begin
        if (!fifo_full) begin
          din_d = {hit_time[idx_q], CH_ID_W'(idx_q)};
          wr_d  = 1'b1;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_TRAILER;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_TRAILER: begin
        if (!fifo_full) begin
          din_d   = TRAILER_WORD[DATA_W-1:0];
          wr_d    = 1'b1;
          evt_d   = evt_q + 16'd1;
          state_d = S_DEAD;
          dcnt_d  = '0;
        end
      end
      S_DEAD: begin
        if (dcnt_q == DCNT_W'(DEAD_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      idx_q       <= '0;
      dcnt_q      <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      missed_q    <= 1'b0;
      evt_q       <= '0;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      idx_q       <= idx_d;
      dcnt_q      <= dcnt_d;
      din_q       <= din_d;
      wr_q        <= wr_d;
      missed_q    <= missed_d;
      evt_q       <= evt_d;
      trig_s1_q   <= scin_coin;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wr_en  = wr_q;
  assign busy        = (state_q != S_IDLE);
  assign missed_trig = missed_q;
  assign evt_count   = evt_q;

endmodule

// File: tb/tb_tube_event_sequencer.sv
// Directed bench for tube_event_sequencer with default parameters
// (NUM_CH=32, TIME_W=8, CH_ID_W=8, WINDOW=254, DEAD_CYCLES=11).
// Honours EVT_HEADER_EN when the design is built with it.
module tb_tube_event_sequencer;

  localparam int NUM_CH = 32;
  localparam int EVLEN  = 254 + 32 + 1 + 11;
`ifdef EVT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic              clk50 = 1'b0;
  logic              rst_n;
  logic              scin_coin;
  logic [NUM_CH-1:0] tube_in;
  logic [15:0]       fifo_din;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              busy;
  logic              missed_trig;
  logic [15:0]       evt_count;

  always #5 clk50 = ~clk50;

  tube_event_sequencer #(
    .NUM_CH(32), .TIME_W(8), .CH_ID_W(8), .WINDOW(254), .DEAD_CYCLES(11)
  ) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .scin_coin   (scin_coin),
    .tube_in     (tube_in),
    .fifo_din    (fifo_din),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .missed_trig (missed_trig),
    .evt_count   (evt_count)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] wq[$];
  int          bcnt = 0;
  int          full_viol = 0;
  logic        full_at_edge = 1'b0;
  logic [7:0]  exp_t [NUM_CH];
  int          exp_evt = 0;

  // Full flag as the DUT saw it at the last edge; a write issued from that edge is illegal.
  always @(posedge clk50) full_at_edge <= fifo_full;

  always @(negedge clk50) begin
    if (fifo_wr_en) begin
      wq.push_back(fifo_din);
      if (full_at_edge) full_viol++;
    end
    if (busy) bcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic set_nohit();
    for (int i = 0; i < NUM_CH; i++) exp_t[i] = 8'hFF;
  endtask

  // Raise the trigger and return in the first capture cycle (tcnt == 0).
  task automatic fire(input string tag);
    int k;
    wq.delete();
    scin_coin = 1'b1;
    k = 0;
    while (!busy && k < 10) begin
      tick(1);
      k++;
    end
    chk({tag, "_start"}, {31'd0, busy}, 32'd1);
    bcnt = 0;
    scin_coin = 1'b0;
`ifdef EVT_HEADER_EN
    tick(1);
`endif
  endtask

  task automatic finish_evt(input string tag, input int len);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      tick(1);
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_len"}, bcnt, len + HDR);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nwords"}, wq.size(), NUM_CH + 1 + HDR);
    if (wq.size() == NUM_CH + 1 + HDR) begin
`ifdef EVT_HEADER_EN
      chk({tag, "_hdr"}, {16'd0, wq[0]}, {16'd0, 8'hA5, exp_evt[7:0]});
`endif
      for (int i = 0; i < NUM_CH; i++)
        chk($sformatf("%s_w%0d", tag, i), {16'd0, wq[HDR+i]}, {16'd0, exp_t[i], 8'(i)});
      chk({tag, "_trailer"}, {16'd0, wq[HDR+NUM_CH]}, 32'h0000_FFFF);
    end
    exp_evt++;
    chk({tag, "_evt"}, {16'd0, evt_count}, exp_evt);
  endtask

  initial begin
    rst_n     = 1'b0;
    scin_coin = 1'b0;
    tube_in   = '0;
    fifo_full = 1'b0;
    set_nohit();
    tick(3);
    chk("rst_busy",   {31'd0, busy},        32'd0);
    chk("rst_wr",     {31'd0, fifo_wr_en},  32'd0);
    chk("rst_din",    {16'd0, fifo_din},    32'd0);
    chk("rst_missed", {31'd0, missed_trig}, 32'd0);
    chk("rst_evt",    {16'd0, evt_count},   32'd0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: no hits
    fire("t1");
    finish_evt("t1", EVLEN);
    check_stream("t1");

    // 2: ch3 high before window, ch5 edges at tcnt 10 and 40, ch31 at 253
    tube_in[3] = 1'b1;
    tick(5);
    fire("t2");
    tick(8);   tube_in[5]  = 1'b1;
    tick(12);  tube_in[5]  = 1'b0;
    tick(18);  tube_in[5]  = 1'b1;
    tick(213); tube_in[31] = 1'b1;
    finish_evt("t2", EVLEN);
    exp_t[5]  = 8'h0A;
    exp_t[31] = 8'hFD;
    check_stream("t2");
    tube_in = '0;
    set_nohit();
    tick(3);

    // 3: full for three sampled edges while idx 7 is pending
    fire("t3");
    tick(261);
    fifo_full = 1'b1;
    tick(3);
    chk("t3_stall_wr", {31'd0, fifo_wr_en}, 32'd0);
    fifo_full = 1'b0;
    finish_evt("t3", EVLEN + 3);
    check_stream("t3");
    chk("t3_full_viol", full_viol, 32'd0);

    // 4: second trigger during READOUT, then level-high is ignored, then a clean edge
    chk("t4_pre_missed", {31'd0, missed_trig}, 32'd0);
    fire("t4");
    tick(262);
    scin_coin = 1'b1;
    finish_evt("t4", EVLEN);
    chk("t4_missed", {31'd0, missed_trig}, 32'd1);
    check_stream("t4");
    tick(20);
    chk("t4_level_ignored", {31'd0, busy}, 32'd0);
    scin_coin = 1'b0;
    tick(3);
    fire("t4b");
    finish_evt("t4b", EVLEN);
    check_stream("t4b");
    chk("t4_sticky", {31'd0, missed_trig}, 32'd1);

    // 5: reset mid-capture drops the event and clears the TDCs
    fire("t5");
    tick(3);
    tube_in[2] = 1'b1;
    tick(40);
    rst_n = 1'b0;
    tick(1);
    chk("t5_busy",   {31'd0, busy},        32'd0);
    chk("t5_wr",     {31'd0, fifo_wr_en},  32'd0);
    chk("t5_din",    {16'd0, fifo_din},    32'd0);
    chk("t5_evt",    {16'd0, evt_count},   32'd0);
    chk("t5_missed", {31'd0, missed_trig}, 32'd0);
    rst_n   = 1'b1;
    tube_in = '0;
    exp_evt = 0;
    tick(5);
    chk("t5_no_words", wq.size(), HDR);
    fire("t5b");
    finish_evt("t5b", EVLEN);
    check_stream("t5b");

    chk("full_viol_final", full_viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
